// File: rtl/uart_frame_regbank.sv
// UART command framer and byte register bank: HEADER,CMD,DATA,CHK frames write or read NUM_REGS registers.
// Optional response path towards the transmitter is built only when UART_FRAME_ACK_EN is defined.
module uart_frame_regbank #(
  parameter int          NUM_REGS       = 8,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 500_000,
  parameter logic [7:0]  ACK_OK         = 8'h5A,
  parameter logic [7:0]  ACK_ERR        = 8'hEE
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [8*NUM_REGS-1:0]   regs_flat,
  output logic                    wr_strobe,
  output logic [6:0]              wr_addr,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    frame_err,
  output logic                    ack_overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_DATA} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cmd_q, data_q;
  logic [TW-1:0]           tout_q, tout_d;
  logic [8*NUM_REGS-1:0]   regs_q, regs_d;
  logic                    wr_strobe_q;
  logic [6:0]              wr_addr_q;
  logic                    frame_err_q;

  logic       tout_hit;
  logic       frame_eval, chk_ok, addr_ok, frame_ok;
  logic       wr_en, resp_vld, err_set;
  logic [7:0] resp_dat, rd_dat;

  // A byte on the same edge as expiry wins, so rx_valid masks the timeout.
  assign tout_hit = (state_q != IDLE) && (tout_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        IDLE:     if (rx_data == HEADER) state_d = GOT_HDR;
        GOT_HDR:  state_d = GOT_CMD;
        GOT_CMD:  state_d = GOT_DATA;
        GOT_DATA: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end else if (tout_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_q[6:0] == 7'(i)) rd_dat = regs_q[8*i +: 8];
  end

  always_comb begin
    frame_eval = rx_valid && (state_q == GOT_DATA);
    chk_ok     = ((cmd_q ^ data_q) == rx_data);
    addr_ok    = ({1'b0, cmd_q[6:0]} < 8'(NUM_REGS));
    frame_ok   = chk_ok && addr_ok;
    wr_en      = frame_eval && frame_ok && !cmd_q[7];
    resp_vld   = frame_eval;
    resp_dat   = !frame_ok ? ACK_ERR : (cmd_q[7] ? rd_dat : ACK_OK);
    err_set    = (frame_eval && !frame_ok) || (!rx_valid && tout_hit);
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++)
      if (wr_en && cmd_q[6:0] == 7'(i)) regs_d[8*i +: 8] = data_q;
  end

  always_comb begin
    tout_d = '0;
    if (!rx_valid && state_q != IDLE && !tout_hit) tout_d = tout_q + TW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
      tout_q      <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_valid && state_q == GOT_HDR) cmd_q  <= rx_data;
      if (rx_valid && state_q == GOT_CMD) data_q <= rx_data;
      tout_q      <= tout_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_en;
      if (wr_en)   wr_addr_q   <= cmd_q[6:0];
      if (err_set) frame_err_q <= 1'b1;
    end
  end

  assign regs_flat = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

`ifdef UART_FRAME_ACK_EN
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       ack_overrun_q;

  // Single-entry buffer: a handshake in the same cycle frees the slot for the new response.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      ack_overrun_q <= 1'b0;
    end else if (resp_vld) begin
      if (!tx_valid_q || tx_ready) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= resp_dat;
      end else begin
        ack_overrun_q <= 1'b1;
      end
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign ack_overrun = ack_overrun_q;
`else
  logic unused_resp;
  assign unused_resp = ^{tx_ready, resp_vld, resp_dat};
  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h00;
  assign ack_overrun = 1'b0;
`endif

endmodule

// File: doc/uart_frame_regbank.md
# uart_frame_regbank

Parametrised UART command receiver and register bank, replacing the direct byte-to-display wiring in the top level. It parses framed writes and reads from the UART receiver's byte stream, validates each frame with an XOR checksum and an inter-byte timeout, and stores the data in `NUM_REGS` byte registers. The flattened bank feeds the seven-segment display data path. An optional acknowledge/readback byte goes back towards the UART transmitter.

## Interface
- `NUM_REGS`, 8: number of 8-bit registers; legal range 1..128.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, 500_000: maximum idle cycles between bytes of one frame (10 ms at 50 MHz); minimum 2.
- `ACK_OK`, 8'h5A / `ACK_ERR`, 8'hEE: response codes.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous active-low reset; single clock domain, no internal synchroniser.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  single-cycle strobe per received byte.
- `regs_flat`  out  8*NUM_REGS  register bank; reg *i* is at bits [8i+7:8i].
- `wr_strobe`  out  1  one-cycle pulse on every accepted write.
- `wr_addr`  out  7  address of the last accepted write.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response pending; held until `tx_ready`.
- `tx_ready`  in  1  transmitter accepts `tx_data` when `tx_valid && tx_ready`.
- `frame_err`  out  1  sticky: checksum, range or timeout error seen.
- `ack_overrun`  out  1  sticky: a response was dropped because the previous one was still pending.

## Operation
- Frame format: `HEADER`, `CMD`, `DATA`, `CHK`, where `CHK = CMD ^ DATA`.
  - `CMD[7]=0`: write `DATA` to reg `CMD[6:0]`.
  - `CMD[7]=1`: read reg `CMD[6:0]`; `DATA` is ignored but still enters the checksum.
- FSM states: IDLE, GOT_HDR, GOT_CMD, GOT_DATA. Each state advances only on `rx_valid`.
  - IDLE: a byte equal to `HEADER` moves to GOT_HDR; any other byte is discarded silently.
  - GOT_HDR: latch `CMD`, move to GOT_CMD.
  - GOT_CMD: latch `DATA`, move to GOT_DATA.
  - GOT_DATA: evaluate the frame, always return to IDLE.
- Evaluation in GOT_DATA:
  - Checksum match, address < `NUM_REGS`, write command: update the register, pulse `wr_strobe`, update `wr_addr`, respond `ACK_OK`.
  - Checksum match, address < `NUM_REGS`, read command: respond with the register value.
  - Checksum mismatch or address ≥ `NUM_REGS`: no update, respond `ACK_ERR`, set `frame_err`.
- A `HEADER` value inside GOT_HDR, GOT_CMD or GOT_DATA is treated as data. There is no resynchronisation mid-frame; the timeout is the only recovery.
- Timeout: a counter clears on every `rx_valid` and counts while the FSM is not in IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, sets `frame_err`, and sends no response.
- Response buffer (one entry):
  - A new response while `tx_valid=0` loads `tx_data` and sets `tx_valid`.
  - A new response while `tx_valid=1` and no handshake in the same cycle is dropped and sets `ack_overrun`. The register write still takes effect.
  - If the handshake and a new response occur in the same cycle, the new response loads and `tx_valid` stays 1.
- Reset values: all registers 8'h00, `regs_flat` 0, `wr_strobe` 0, `wr_addr` 0, `tx_data` 0, `tx_valid` 0, `frame_err` 0, `ack_overrun` 0, FSM IDLE, timeout counter 0.
- Reset asserted mid-frame aborts the frame immediately, clears a pending response and restores all reset values.

## Timing
- All outputs are registered.
- Let E be the clock edge that samples `CHK` with `rx_valid=1`. At E:
  - the register update becomes visible on `regs_flat`;
  - `wr_strobe` goes high for exactly one cycle;
  - `tx_valid` rises.
  
  Latency from the `CHK` strobe to output is therefore one edge.
- A read returns the register value as it stood before edge E.
- Back-to-back `rx_valid` on consecutive cycles must be accepted: throughput is one byte per clock.
- The timeout fires on the edge where the counter reaches `TIMEOUT_CYCLES`. If `rx_valid` arrives on that same edge, the byte wins: the counter clears and the FSM advances normally.
- `tx_data` is stable while `tx_valid=1` and `tx_ready=0`.

## Configuration
- Macro `UART_FRAME_ACK_EN`.
- Defined: response path as described, including read commands.
- Undefined:
  - `tx_valid`, `tx_data` and `ack_overrun` are tied to 0 and the response buffer is not synthesised;
  - a read command is parsed and checked, but has no visible effect except `frame_err` on error;
  - writes, `frame_err` and timeout behave identically to the defined case.

## Test plan
- Write frame A5 03 7C 7F with `tx_ready=1` → reg 3 = 8'h7C (bits [31:24]) at the edge sampling 7F, one `wr_strobe` pulse, `wr_addr=3`, `tx_data=8'h5A`.
- Bad checksum A5 02 11 00 → no register change, `tx_data=8'hEE`, `frame_err=1`. Address out of range with `NUM_REGS=8`, A5 09 01 08 → same response.
- Read: after the write in the first test, send A5 83 00 83 → `tx_data=8'h7C`, no `wr_strobe`.
- Timeout: send A5 01, then idle for `TIMEOUT_CYCLES` cycles → FSM returns to IDLE, `frame_err=1`, no response. A following complete frame is processed normally.
- Overrun: hold `tx_ready=0` and send two valid write frames back to back → both registers update, `tx_data` keeps the first `ACK_OK`, `ack_overrun=1`.
- Reset during GOT_DATA with a response pending → all outputs return to reset values. The next frame decodes correctly. Repeat with the macro undefined: `tx_valid` stays 0 throughout.
